// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch / load-store memory port arbiter.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Requester indices; also the bit positions in the req/grant vectors.
    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU requesters, the arbiter and the memory.
// The slave view is the arbiter; the master view is everything around it.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    // Fetch port
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_ack;
    logic [DATA_W-1:0] f_rdata;

    // Load/store port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    // Memory side
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_datain;
    logic              mem_re;
    logic              mem_we;
    logic [DATA_W-1:0] mem_dataout;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_dataout,
        output f_ack, f_rdata, d_ack, d_rdata, mem_addr, mem_datain, mem_re, mem_we
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_dataout,
        input  f_ack, f_rdata, d_ack, d_rdata, mem_addr, mem_datain, mem_re, mem_we
    );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester always wins; on a tie the
// requester that was not granted last time wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // One-hot grant from the request pair and the previous winner
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last == PORT_D) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port word memory between instruction fetch (F) and
// load/store (D). One transaction at a time: grant in IDLE, hold the latched
// operands for WAIT_STATES+1 BUSY cycles, then pulse the granted ack.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WAIT_STATES = 0,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    arb_state_t        state;
    arb_state_t        state_next;
    logic [1:0]        req;
    logic [1:0]        grant;
    logic              pick;
    logic              take;
    logic              cnt_zero;
    logic              last_grant;
    logic              gnt_port;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [3:0]        cnt;
    logic              f_ack_q;
    logic              d_ack_q;
    logic [DATA_W-1:0] f_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    assign req[PORT_F] = bus.f_req;
    assign req[PORT_D] = bus.d_req;

    rr_pick2 u_pick (
        .req   (req),
        .last  (last_grant),
        .grant (grant)
    );

    assign pick     = grant[PORT_D];
    assign take     = (state == IDLE) && (req != 2'b00);
    assign cnt_zero = (cnt == 4'd0);

    // State register; reset drops the strobes at once since they decode from it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state: leave IDLE on any request, leave BUSY when the wait count is spent
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (take) state_next = BUSY;
            BUSY:    if (cnt_zero) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Grant latching, wait countdown, read-data capture and one-cycle acks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= PORT_D;
            gnt_port   <= PORT_F;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            cnt        <= 4'd0;
            f_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            f_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            f_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            if (take) begin
                gnt_port   <= pick;
                last_grant <= pick;
                cnt        <= WAIT_INIT;
                if (pick == PORT_D) begin
                    lat_addr  <= bus.d_addr;
                    lat_we    <= bus.d_we;
                    lat_wdata <= bus.d_wdata;
                end else begin
                    lat_addr  <= bus.f_addr;
                    lat_we    <= 1'b0;
                end
            end else if (state == BUSY) begin
                if (!cnt_zero) begin
                    cnt <= cnt - 4'd1;
                end else if (gnt_port == PORT_D) begin
                    d_ack_q <= 1'b1;
                    if (!lat_we) d_rdata_q <= bus.mem_dataout;
                end else begin
                    f_ack_q   <= 1'b1;
                    f_rdata_q <= bus.mem_dataout;
                end
            end
        end
    end

    // Reads strobe re for the whole access; a store strobes we only on the
    // final BUSY cycle so memory sees exactly one write edge.
    assign bus.mem_re     = (state == BUSY) && !lat_we;
    assign bus.mem_we     = (state == BUSY) && lat_we && cnt_zero;
    assign bus.mem_addr   = lat_addr;
    assign bus.mem_datain = lat_wdata;
    assign bus.f_ack      = f_ack_q;
    assign bus.d_ack      = d_ack_q;
    assign bus.f_rdata    = f_rdata_q;
    assign bus.d_rdata    = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance with no wait states, one with three,
// each backed by a small word memory.
module tb_mem_port_arbiter
    import mem_arb_pkg::*;
;

    logic clk;
    logic reset0;
    logic reset3;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus0 ();
    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus3 ();

    mem_port_arbiter #(.WAIT_STATES(0), .ADDR_W(16), .DATA_W(16)) dut0 (
        .clk   (clk),
        .reset (reset0),
        .bus   (bus0)
    );

    mem_port_arbiter #(.WAIT_STATES(3), .ADDR_W(16), .DATA_W(16)) dut3 (
        .clk   (clk),
        .reset (reset3),
        .bus   (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memories with a preload path used while the DUTs are held in reset
    logic [15:0] mem0 [0:255];
    logic [15:0] mem3 [0:255];
    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [15:0] pl_data;

    assign bus0.mem_dataout = mem0[bus0.mem_addr[7:0]];
    assign bus3.mem_dataout = mem3[bus3.mem_addr[7:0]];

    always @(posedge clk) begin
        if (pl_en) begin
            mem0[pl_addr] <= pl_data;
            mem3[pl_addr] <= pl_data;
        end else begin
            if (bus0.mem_we) mem0[bus0.mem_addr[7:0]] <= bus0.mem_datain;
            if (bus3.mem_we) mem3[bus3.mem_addr[7:0]] <= bus3.mem_datain;
        end
    end

    int both0 = 0;
    int both3 = 0;
    always @(negedge clk) begin
        if (bus0.mem_re && bus0.mem_we) both0 <= both0 + 1;
        if (bus3.mem_re && bus3.mem_we) both3 <= both3 + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Wait (bounded) for any ack on the zero-wait instance; counts cycles and write strobes
    task automatic wait_ack0(output int cyc, output logic gf, output logic gd, output int wec);
        cyc = 0; wec = 0; gf = 1'b0; gd = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            if (bus0.mem_we) wec++;
            gf = bus0.f_ack;
            gd = bus0.d_ack;
        end while (!(gf || gd) && cyc < 40);
    endtask

    typedef struct {
        logic        port;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_f;
        logic [15:0] exp_d;
        int          exp_we;
    } vec_t;

    vec_t        tbl [6];
    logic [15:0] ref_mem [0:255];
    logic [15:0] m_f;
    logic [15:0] m_d;
    logic        m_last;
    int          cyc;
    int          wec;
    int          acks;
    logic        gf;
    logic        gd;

    initial begin
        tbl[0] = '{PORT_F, 1'b0, 16'd20, 16'h0000, 16'h8002, 16'h0000, 0};
        tbl[1] = '{PORT_D, 1'b1, 16'd5,  16'hBEEF, 16'h8002, 16'h0000, 1};
        tbl[2] = '{PORT_D, 1'b0, 16'd5,  16'h0000, 16'h8002, 16'hBEEF, 0};
        tbl[3] = '{PORT_D, 1'b1, 16'd6,  16'h1234, 16'h8002, 16'hBEEF, 1};
        tbl[4] = '{PORT_F, 1'b0, 16'd6,  16'h0000, 16'h1234, 16'hBEEF, 0};
        tbl[5] = '{PORT_D, 1'b0, 16'd20, 16'h0000, 16'h1234, 16'h8002, 0};

        reset0 = 1'b1; reset3 = 1'b1;
        bus0.f_req = 1'b0; bus0.f_addr = '0; bus0.d_req = 1'b0; bus0.d_we = 1'b0;
        bus0.d_addr = '0; bus0.d_wdata = '0;
        bus3.f_req = 1'b0; bus3.f_addr = '0; bus3.d_req = 1'b0; bus3.d_we = 1'b0;
        bus3.d_addr = '0; bus3.d_wdata = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;

        // Preload while in reset; clear the low words used by the tests first
        @(negedge clk);
        pl_en = 1'b1;
        for (int i = 0; i < 48; i++) begin
            pl_addr = 8'(i);
            pl_data = (i == 20) ? 16'h8002 : (i == 9) ? 16'h0A0B : (i == 40) ? 16'h1111 : 16'h0000;
            @(negedge clk);
        end
        pl_en = 1'b0;
        ref_mem[20] = 16'h8002; ref_mem[9] = 16'h0A0B; ref_mem[40] = 16'h1111;

        check("rst_strobes0", 32'({bus0.f_ack, bus0.d_ack, bus0.mem_re, bus0.mem_we}), 32'd0);
        check("rst_rdata0",   {bus0.f_rdata, bus0.d_rdata}, 32'd0);
        check("rst_membus0",  {bus0.mem_addr, bus0.mem_datain}, 32'd0);
        check("rst_strobes3", 32'({bus3.f_ack, bus3.d_ack, bus3.mem_re, bus3.mem_we}), 32'd0);

        reset0 = 1'b0; reset3 = 1'b0;
        @(negedge clk);
        check("idle_no_req", 32'({bus0.f_ack, bus0.d_ack, bus0.mem_re, bus0.mem_we}), 32'd0);

        // Single transactions from the vector table
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].port == PORT_F) begin
                bus0.f_req = 1'b1; bus0.f_addr = tbl[i].addr;
            end else begin
                bus0.d_req = 1'b1; bus0.d_we = tbl[i].we;
                bus0.d_addr = tbl[i].addr; bus0.d_wdata = tbl[i].wdata;
            end
            wait_ack0(cyc, gf, gd, wec);
            bus0.f_req = 1'b0; bus0.d_req = 1'b0;
            check($sformatf("tbl%0d_latency", i), 32'(cyc), 32'd2);
            check($sformatf("tbl%0d_ackport", i), 32'({gf, gd}),
                  (tbl[i].port == PORT_F) ? 32'd2 : 32'd1);
            check($sformatf("tbl%0d_f_rdata", i), 32'(bus0.f_rdata), 32'(tbl[i].exp_f));
            check($sformatf("tbl%0d_d_rdata", i), 32'(bus0.d_rdata), 32'(tbl[i].exp_d));
            check($sformatf("tbl%0d_we_cycles", i), 32'(wec), 32'(tbl[i].exp_we));
            if (tbl[i].we) ref_mem[tbl[i].addr[7:0]] = tbl[i].wdata;
        end

        // Both ports held high continuously: acks alternate F, D, F, D
        @(negedge clk);
        bus0.f_req = 1'b1; bus0.f_addr = 16'd5;
        bus0.d_req = 1'b1; bus0.d_we = 1'b0; bus0.d_addr = 16'd6;
        for (int k = 0; k < 4; k++) begin
            wait_ack0(cyc, gf, gd, wec);
            check($sformatf("rr%0d_gap", k), 32'(cyc), 32'd2);
            check($sformatf("rr%0d_ackport", k), 32'({gf, gd}), (k % 2 == 0) ? 32'd2 : 32'd1);
            if (k % 2 == 0) check($sformatf("rr%0d_f_rdata", k), 32'(bus0.f_rdata), 32'hBEEF);
            else            check($sformatf("rr%0d_d_rdata", k), 32'(bus0.d_rdata), 32'h1234);
        end
        bus0.f_req = 1'b0; bus0.d_req = 1'b0;

        // Back-to-back loads: new address presented in the ack cycle
        @(negedge clk);
        bus0.d_req = 1'b1; bus0.d_we = 1'b0; bus0.d_addr = 16'd5;
        wait_ack0(cyc, gf, gd, wec);
        check("b2b_first_lat", 32'(cyc), 32'd2);
        check("b2b_first_data", 32'({gd, bus0.d_rdata}), 32'h1BEEF);
        bus0.d_addr = 16'd20;
        wait_ack0(cyc, gf, gd, wec);
        bus0.d_req = 1'b0;
        check("b2b_second_gap", 32'(cyc), 32'd2);
        check("b2b_second_data", 32'({gd, bus0.d_rdata}), 32'h18002);

        // Randomised traffic against a transaction-level model
        m_f = 16'hBEEF; m_d = 16'h8002; m_last = PORT_D;
        for (int it = 0; it < 80; it++) begin
            logic [15:0] fa;
            logic [15:0] da;
            logic [15:0] wd;
            logic        we;
            logic        first_p;
            logic        p;
            int          mode;
            int          n;
            mode = $urandom_range(1, 3);
            fa   = 16'($urandom_range(0, 31));
            da   = 16'($urandom_range(0, 31));
            wd   = 16'($urandom);
            we   = 1'($urandom_range(0, 1));
            if (mode != 2) begin bus0.f_req = 1'b1; bus0.f_addr = fa; end
            if (mode != 1) begin
                bus0.d_req = 1'b1; bus0.d_we = we; bus0.d_addr = da; bus0.d_wdata = wd;
            end
            n = (mode == 3) ? 2 : 1;
            if (mode == 1)      first_p = PORT_F;
            else if (mode == 2) first_p = PORT_D;
            else                first_p = (m_last == PORT_F) ? PORT_D : PORT_F;
            for (int k = 0; k < n; k++) begin
                p = (k == 0) ? first_p : ~first_p;
                wait_ack0(cyc, gf, gd, wec);
                check("rnd_latency", 32'(cyc), 32'd2);
                check("rnd_ackport", 32'({gf, gd}), (p == PORT_F) ? 32'd2 : 32'd1);
                if (p == PORT_F) begin
                    m_f = ref_mem[fa[7:0]];
                    bus0.f_req = 1'b0;
                end else begin
                    if (we) ref_mem[da[7:0]] = wd;
                    else    m_d = ref_mem[da[7:0]];
                    bus0.d_req = 1'b0;
                end
                check("rnd_f_rdata", 32'(bus0.f_rdata), 32'(m_f));
                check("rnd_d_rdata", 32'(bus0.d_rdata), 32'(m_d));
                m_last = p;
            end
        end

        // Three wait states: load, operands changed mid-access
        @(negedge clk);
        bus3.d_req = 1'b1; bus3.d_we = 1'b0; bus3.d_addr = 16'd9;
        cyc = 0; wec = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (bus3.mem_re) wec++;
            if (cyc == 1) bus3.d_addr = 16'd30;
            if (cyc == 2) check("ws3_addr_held", 32'(bus3.mem_addr), 32'd9);
        end while (!bus3.d_ack && cyc < 40);
        bus3.d_req = 1'b0;
        check("ws3_latency", 32'(cyc), 32'd5);
        check("ws3_re_cycles", 32'(wec), 32'd4);
        check("ws3_d_rdata", 32'(bus3.d_rdata), 32'h0A0B);

        // Three wait states: store aborted by reset in its second BUSY cycle
        @(negedge clk);
        bus3.d_req = 1'b1; bus3.d_we = 1'b1; bus3.d_addr = 16'd40; bus3.d_wdata = 16'hCAFE;
        acks = 0; wec = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus3.d_ack) acks++;
            if (bus3.mem_we) wec++;
        end
        check("abort_in_busy", 32'(bus3.mem_addr), 32'd40);
        reset3 = 1'b1;
        bus3.d_req = 1'b0;
        #1;
        check("abort_strobes", 32'({bus3.f_ack, bus3.d_ack, bus3.mem_re, bus3.mem_we}), 32'd0);
        check("abort_rdata", {bus3.f_rdata, bus3.d_rdata}, 32'd0);
        check("abort_membus", {bus3.mem_addr, bus3.mem_datain}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            if (bus3.d_ack) acks++;
            if (bus3.mem_we) wec++;
        end
        reset3 = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus3.d_ack) acks++;
            if (bus3.mem_we) wec++;
        end
        check("abort_no_ack", 32'(acks), 32'd0);
        check("abort_no_write", 32'(wec), 32'd0);
        check("abort_word_kept", 32'(mem3[40]), 32'h1111);

        check("strobe_overlap0", 32'(both0), 32'd0);
        check("strobe_overlap3", 32'(both3), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
